// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared types and constants for the MAC job sequencer.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    // Beats per accumulation group fed to the MAC
    localparam int unsigned ACC_BEATS = 4;
    localparam int unsigned BEAT_W    = $clog2(ACC_BEATS);

    // Width of credit / occupancy counters able to hold 0..depth
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mac_res_fifo.sv
// mac_res_fifo: synchronous result FIFO with ready/valid output and an
// occupancy count used by the sequencer's credit computation.
// Push and pop in the same cycle leave occupancy unchanged.
module mac_res_fifo
    import mac_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 push_data,
    output logic                             valid,
    input  logic                             ready,
    output logic [WIDTH-1:0]                 data,
    output logic [credit_width(DEPTH)-1:0]   count
);

    localparam int unsigned CW = credit_width(DEPTH);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign valid = (count != '0);
    assign full  = (count == CW'(DEPTH));
    // Head entry is gated so the output reads zero when empty
    assign data  = valid ? mem[rd_ptr] : '0;

    // Accept a push when space exists or a pop frees a slot this cycle
    always_comb begin
        do_pop  = valid && ready;
        do_push = push && (!full || do_pop);
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer for the packed dual-weight MAC. Streams weight
// pairs and feature bytes in 4-beat groups, issues groups only when result
// credit is available, and collects psum pairs into a result FIFO.
// Optional feature: define MAC_SEQ_RELU_EN to clamp negative psum lanes to 0.
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_I = 8,
    parameter int unsigned DATA_WIDTH_O = 18,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned GRP_W        = 8,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [GRP_W-1:0]          num_grp,
    input  logic [ADDR_W-1:0]         w_base,
    input  logic [ADDR_W-1:0]         f_base,
    output logic                      busy,
    output logic                      done,
    output logic                      w_rd_en,
    output logic [ADDR_W-1:0]         w_rd_addr,
    input  logic [2*DATA_WIDTH_I-1:0] w_rd_data,
    output logic                      f_rd_en,
    output logic [ADDR_W-1:0]         f_rd_addr,
    input  logic [DATA_WIDTH_I-1:0]   f_rd_data,
    output logic                      mac_en_in,
    output logic [DATA_WIDTH_I-1:0]   mac_w1,
    output logic [DATA_WIDTH_I-1:0]   mac_w2,
    output logic [DATA_WIDTH_I-1:0]   mac_b,
    input  logic                      mac_en_out,
    input  logic [DATA_WIDTH_O-1:0]   mac_psum0,
    input  logic [DATA_WIDTH_O-1:0]   mac_psum1,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*DATA_WIDTH_O-1:0] res_data
);

    localparam int unsigned CW = credit_width(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_CNT = (CW + 1)'(FIFO_DEPTH);

    seq_state_t          state;
    logic [GRP_W-1:0]    num_lat;
    logic [ADDR_W-1:0]   f_lat;
    logic [ADDR_W-1:0]   w_next;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   beat_nxt;
    logic [GRP_W-1:0]    grp_cnt;
    logic [GRP_W-1:0]    rcv_cnt;
    logic [CW-1:0]       in_flight;
    logic [CW-1:0]       fifo_count;
    logic                credit_ok;
    logic                beat_cont;
    logic                grp_start;
    logic                issue;
    logic [DATA_WIDTH_O-1:0] lane0;
    logic [DATA_WIDTH_O-1:0] lane1;

    // Operands pass straight through; the read data lines up with mac_en_in
    assign mac_w1 = w_rd_data[DATA_WIDTH_I-1:0];
    assign mac_w2 = w_rd_data[2*DATA_WIDTH_I-1:DATA_WIDTH_I];
    assign mac_b  = f_rd_data;

    // Issue decision: continue the current group, or open a new one on credit.
    // Credit uses registered counts; a same-cycle pop is ignored, which can
    // only delay a group start by a cycle, never overcommit the FIFO.
    always_comb begin
        credit_ok = ({1'b0, fifo_count} + {1'b0, in_flight}) < DEPTH_CNT;
        beat_cont = (state == S_ISSUE) && w_rd_en &&
                    (beat != BEAT_W'(ACC_BEATS - 1));
        grp_start = 1'b0;
        if (credit_ok) begin
            if (state == S_IDLE) begin
                grp_start = start && (num_grp != '0);
            end else if (state == S_ISSUE) begin
                grp_start = !beat_cont && (grp_cnt != num_lat);
            end
        end
        issue    = beat_cont || grp_start;
        beat_nxt = grp_start ? '0 : beat + BEAT_W'(1);
    end

    // Optional ReLU on each psum lane before it enters the FIFO
    always_comb begin
        lane0 = mac_psum0;
        lane1 = mac_psum1;
`ifdef MAC_SEQ_RELU_EN
        if (mac_psum0[DATA_WIDTH_O-1]) lane0 = '0;
        if (mac_psum1[DATA_WIDTH_O-1]) lane1 = '0;
`endif
    end

    // Job FSM with registered read requests, credits and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            w_rd_en   <= 1'b0;
            f_rd_en   <= 1'b0;
            w_rd_addr <= '0;
            f_rd_addr <= '0;
            mac_en_in <= 1'b0;
            num_lat   <= '0;
            f_lat     <= '0;
            w_next    <= '0;
            beat      <= '0;
            grp_cnt   <= '0;
            rcv_cnt   <= '0;
            in_flight <= '0;
        end else begin
            mac_en_in <= w_rd_en;
            in_flight <= in_flight + CW'(grp_start) - CW'(mac_en_out);
            if (mac_en_out) begin
                rcv_cnt <= rcv_cnt + GRP_W'(1);
            end
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        num_lat <= num_grp;
                        f_lat   <= f_base;
                        rcv_cnt <= '0;
                        if (num_grp == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ISSUE;
                            busy  <= 1'b1;
                            if (grp_start) begin
                                w_rd_en   <= 1'b1;
                                f_rd_en   <= 1'b1;
                                w_rd_addr <= w_base;
                                f_rd_addr <= f_base;
                                w_next    <= w_base + ADDR_W'(1);
                                beat      <= '0;
                                grp_cnt   <= GRP_W'(1);
                            end else begin
                                w_next  <= w_base;
                                grp_cnt <= '0;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue) begin
                        w_rd_en   <= 1'b1;
                        f_rd_en   <= 1'b1;
                        w_rd_addr <= w_next;
                        w_next    <= w_next + ADDR_W'(1);
                        f_rd_addr <= f_lat + ADDR_W'(beat_nxt);
                        beat      <= beat_nxt;
                        if (grp_start) begin
                            grp_cnt <= grp_cnt + GRP_W'(1);
                        end
                    end else begin
                        w_rd_en <= 1'b0;
                        f_rd_en <= 1'b0;
                        if (grp_cnt == num_lat) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Count this cycle's strobe so done follows the last result by one cycle
                    if (rcv_cnt + GRP_W'(mac_en_out) == num_lat) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    mac_res_fifo #(
        .WIDTH (2 * DATA_WIDTH_O),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (mac_en_out),
        .push_data ({lane1, lane0}),
        .valid     (res_valid),
        .ready     (res_ready),
        .data      (res_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed bench for mac_seq_ctrl with behavioural buffer
// memories and a 4-beat dual-lane MAC model (3-cycle result latency).
module tb_mac_seq_ctrl;

    localparam int unsigned DI = 8;
    localparam int unsigned DO = 18;
    localparam int unsigned AW = 10;
    localparam int unsigned GW = 8;
    localparam int unsigned FD = 4;

`ifdef MAC_SEQ_RELU_EN
    localparam logic [2*DO-1:0] EXP1 = {18'h00000, 18'h00014};
`else
    localparam logic [2*DO-1:0] EXP1 = {18'h3FFE2, 18'h00014};
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [GW-1:0]   num_grp;
    logic [AW-1:0]   w_base;
    logic [AW-1:0]   f_base;
    logic            busy;
    logic            done;
    logic            w_rd_en;
    logic [AW-1:0]   w_rd_addr;
    logic [2*DI-1:0] w_rd_data;
    logic            f_rd_en;
    logic [AW-1:0]   f_rd_addr;
    logic [DI-1:0]   f_rd_data;
    logic            mac_en_in;
    logic [DI-1:0]   mac_w1;
    logic [DI-1:0]   mac_w2;
    logic [DI-1:0]   mac_b;
    logic            mac_en_out;
    logic [DO-1:0]   mac_psum0;
    logic [DO-1:0]   mac_psum1;
    logic            res_valid;
    logic            res_ready;
    logic [2*DO-1:0] res_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_seq_ctrl #(
        .DATA_WIDTH_I (DI),
        .DATA_WIDTH_O (DO),
        .ADDR_W       (AW),
        .GRP_W        (GW),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_grp    (num_grp),
        .w_base     (w_base),
        .f_base     (f_base),
        .busy       (busy),
        .done       (done),
        .w_rd_en    (w_rd_en),
        .w_rd_addr  (w_rd_addr),
        .w_rd_data  (w_rd_data),
        .f_rd_en    (f_rd_en),
        .f_rd_addr  (f_rd_addr),
        .f_rd_data  (f_rd_data),
        .mac_en_in  (mac_en_in),
        .mac_w1     (mac_w1),
        .mac_w2     (mac_w2),
        .mac_b      (mac_b),
        .mac_en_out (mac_en_out),
        .mac_psum0  (mac_psum0),
        .mac_psum1  (mac_psum1),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data)
    );

    // Buffer memories, 1-cycle read latency
    logic [2*DI-1:0] wmem [1024];
    logic [DI-1:0]   fmem [1024];

    always @(posedge clk) begin
        w_rd_data <= wmem[w_rd_addr];
        f_rd_data <= fmem[f_rd_addr];
    end

    // MAC model: accumulate 4 beats per lane, emit after 3 cycles
    logic signed [DO-1:0] prod0, prod1, acc0, acc1;
    logic [DO-1:0] pd0 [3];
    logic [DO-1:0] pd1 [3];
    logic [2:0]    pv;
    logic [1:0]    m_beat;

    assign prod0 = $signed({{10{mac_w1[7]}}, mac_w1}) * $signed({{10{mac_b[7]}}, mac_b});
    assign prod1 = $signed({{10{mac_w2[7]}}, mac_w2}) * $signed({{10{mac_b[7]}}, mac_b});
    assign mac_en_out = pv[2];
    assign mac_psum0  = pd0[2];
    assign mac_psum1  = pd1[2];

    always @(posedge clk) begin
        if (rst) begin
            pv     <= '0;
            m_beat <= '0;
            acc0   <= '0;
            acc1   <= '0;
        end else begin
            pv[0] <= 1'b0;
            if (mac_en_in) begin
                if (m_beat == 2'd3) begin
                    pd0[0] <= acc0 + prod0;
                    pd1[0] <= acc1 + prod1;
                    pv[0]  <= 1'b1;
                    acc0   <= '0;
                    acc1   <= '0;
                end else begin
                    acc0 <= acc0 + prod0;
                    acc1 <= acc1 + prod1;
                end
                m_beat <= m_beat + 2'd1;
            end
            pv[2:1] <= pv[1:0];
            pd0[1]  <= pd0[0];
            pd0[2]  <= pd0[1];
            pd1[1]  <= pd1[0];
            pd1[2]  <= pd1[1];
        end
    end

    // Monitor: cycle count, read beats, address logs, done pulses, occupancy
    int cyc = 0;
    int last_eo = -100;
    int rd_beats = 0;
    int done_cnt = 0;
    int occ = 0;
    bit overflow = 1'b0;
    bit en_mismatch = 1'b0;
    int wq[$];
    int fq[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mac_en_out) last_eo <= cyc;
        if (w_rd_en) begin
            rd_beats <= rd_beats + 1;
            wq.push_back(int'(w_rd_addr));
            fq.push_back(int'(f_rd_addr));
        end
        if (w_rd_en !== f_rd_en) en_mismatch <= 1'b1;
        if (done) done_cnt <= done_cnt + 1;
        if (rst) begin
            occ <= 0;
        end else begin
            if (mac_en_out && occ >= FD && !(res_valid && res_ready)) overflow <= 1'b1;
            occ <= occ + (mac_en_out ? 1 : 0) - ((res_valid && res_ready) ? 1 : 0);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*DO-1:0] exp3(input int g);
        logic signed [DO-1:0] p0, p1;
        p0 = DO'(10 * (g + 1));
        p1 = -p0;
`ifdef MAC_SEQ_RELU_EN
        p1 = '0;
`endif
        return {p1, p0};
    endfunction

    int b0, d0, q0, idx;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            wmem[i] = '0;
            fmem[i] = '0;
        end
        for (int k = 0; k < 4; k++) begin
            wmem[k]       = {8'hFD, 8'h02};
            fmem[k]       = 8'(k + 1);
            fmem[200 + k] = 8'(k + 1);
        end
        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < 4; k++) begin
                wmem[100 + 4 * g + k] = {8'(-(g + 1)), 8'(g + 1)};
            end
        end
        for (int k = 300; k < 308; k++) wmem[k] = {8'd1, 8'd1};

        rst = 1'b1; start = 1'b0; num_grp = '0; w_base = '0; f_base = '0; res_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_w_rd_en", 64'(w_rd_en), 64'd0);
        check("rst_f_rd_en", 64'(f_rd_en), 64'd0);
        check("rst_w_addr", 64'(w_rd_addr), 64'd0);
        check("rst_f_addr", 64'(f_rd_addr), 64'd0);
        check("rst_mac_en_in", 64'(mac_en_in), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        rst = 1'b0;
        tick();

        // Single group: W1=2, W2=-3, features 1..4
        num_grp = 8'd1; w_base = '0; f_base = '0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy_c1", 64'(busy), 64'd1);
        check("t1_rd_en_c1", 64'(w_rd_en), 64'd1);
        check("t1_f_rd_en_c1", 64'(f_rd_en), 64'd1);
        check("t1_w_addr_c1", 64'(w_rd_addr), 64'd0);
        check("t1_mac_en_c1", 64'(mac_en_in), 64'd0);
        tick();
        check("t1_mac_en_c2", 64'(mac_en_in), 64'd1);
        check("t1_w1_c2", 64'(mac_w1), 64'h02);
        check("t1_w2_c2", 64'(mac_w2), 64'hFD);
        check("t1_b_c2", 64'(mac_b), 64'd1);
        check("t1_w_addr_c2", 64'(w_rd_addr), 64'd1);
        check("t1_f_addr_c2", 64'(f_rd_addr), 64'd1);
        for (int i = 0; i < 40 && !done; i++) tick();
        check("t1_done", 64'(done), 64'd1);
        check("t1_done_lat", 64'(cyc - last_eo), 64'd1);
        check("t1_busy_fall", 64'(busy), 64'd0);
        check("t1_res_valid", 64'(res_valid), 64'd1);
        check("t1_res_data", 64'(res_data), 64'(EXP1));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_res_popped", 64'(res_valid), 64'd0);

        // Empty job
        b0 = rd_beats; d0 = done_cnt;
        num_grp = '0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_done_c1", 64'(done), 64'd1);
        check("t2_no_rd_c1", 64'(w_rd_en), 64'd0);
        repeat (5) tick();
        check("t2_no_reads", 64'(rd_beats - b0), 64'd0);
        check("t2_res_valid", 64'(res_valid), 64'd0);
        check("t2_one_done", 64'(done_cnt - d0), 64'd1);

        // Credit stall with consumer blocked, then drain in order
        b0 = rd_beats; d0 = done_cnt;
        num_grp = 8'd8; w_base = 10'd100; f_base = 10'd200; res_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (60) tick();
        check("t3_stall_beats", 64'(rd_beats - b0), 64'd16);
        check("t3_busy_stalled", 64'(busy), 64'd1);
        check("t3_valid_held", 64'(res_valid), 64'd1);
        check("t3_head", 64'(res_data), 64'(exp3(0)));
        tick();
        check("t3_head_stable", 64'(res_data), 64'(exp3(0)));
        res_ready = 1'b1;
        idx = 0;
        for (int i = 0; i < 400 && idx < 8; i++) begin
            if (res_valid) begin
                check($sformatf("t3_res%0d", idx), 64'(res_data), 64'(exp3(idx)));
                idx++;
            end
            tick();
        end
        check("t3_res_count", 64'(idx), 64'd8);
        for (int i = 0; i < 100 && busy; i++) tick();
        check("t3_busy_end", 64'(busy), 64'd0);
        check("t3_one_done", 64'(done_cnt - d0), 64'd1);
        check("t3_total_beats", 64'(rd_beats - b0), 64'd32);
        check("t3_no_overflow", 64'(overflow), 64'd0);

        // Restart attempt while busy is ignored
        q0 = wq.size(); d0 = done_cnt;
        num_grp = 8'd2; w_base = 10'd300; f_base = 10'd200; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        num_grp = 8'd5; w_base = 10'd500; f_base = 10'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && busy; i++) tick();
        repeat (6) tick();
        check("t4_one_done", 64'(done_cnt - d0), 64'd1);
        check("t4_beats", 64'(wq.size() - q0), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_waddr%0d", i), 64'(wq[q0 + i]), 64'(300 + i));
            check($sformatf("t4_faddr%0d", i), 64'(fq[q0 + i]), 64'(200 + i % 4));
        end
        res_ready = 1'b0;

        // Reset in the middle of issue
        d0 = done_cnt;
        num_grp = 8'd4; w_base = 10'd100; f_base = 10'd200; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("t5_mid_issue", 64'(w_rd_en), 64'd1);
        rst = 1'b1;
        tick();
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        check("t5_w_rd_en", 64'(w_rd_en), 64'd0);
        check("t5_f_rd_en", 64'(f_rd_en), 64'd0);
        check("t5_w_addr", 64'(w_rd_addr), 64'd0);
        check("t5_f_addr", 64'(f_rd_addr), 64'd0);
        check("t5_mac_en_in", 64'(mac_en_in), 64'd0);
        check("t5_res_valid", 64'(res_valid), 64'd0);
        check("t5_res_data", 64'(res_data), 64'd0);
        rst = 1'b0;
        repeat (10) tick();
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);
        check("t5_fifo_empty", 64'(res_valid), 64'd0);
        num_grp = 8'd1; w_base = '0; f_base = '0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && !done; i++) tick();
        check("t5_new_done", 64'(done), 64'd1);
        check("t5_new_res", 64'(res_data), 64'(EXP1));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("t5_new_popped", 64'(res_valid), 64'd0);
        check("en_match", 64'(en_mismatch), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
